// File: rtl/lfsr.sv
// Fibonacci-style XNOR LFSR, NUM_BITS wide (3..32), with seed load and
// a combinational "back at seed" flag.
module lfsr #(
  parameter int NUM_BITS = 8
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_Enable,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  output logic [NUM_BITS-1:0] o_LFSR_Data,
  output logic                o_LFSR_Done
);

  if (NUM_BITS < 3 || NUM_BITS > 32) begin : g_bad_width
    $error("lfsr: NUM_BITS=%0d is outside the supported range 3..32", NUM_BITS);
  end

  // One-hot bit for 1-indexed tap position k.
  function automatic logic [31:0] tap(input int k);
    return 32'h1 << (k - 1);
  endfunction

  // Maximal-length XNOR tap sets (XAPP052), expressed as a bit mask over r[1..n].
  function automatic logic [31:0] tap_mask(input int n);
    logic [31:0] m;
    m = '0;
    case (n)
      3:  m = tap(3)  | tap(2);
      4:  m = tap(4)  | tap(3);
      5:  m = tap(5)  | tap(3);
      6:  m = tap(6)  | tap(5);
      7:  m = tap(7)  | tap(6);
      8:  m = tap(8)  | tap(6)  | tap(5) | tap(4);
      9:  m = tap(9)  | tap(5);
      10: m = tap(10) | tap(7);
      11: m = tap(11) | tap(9);
      12: m = tap(12) | tap(6)  | tap(4) | tap(1);
      13: m = tap(13) | tap(4)  | tap(3) | tap(1);
      14: m = tap(14) | tap(5)  | tap(3) | tap(1);
      15: m = tap(15) | tap(14);
      16: m = tap(16) | tap(15) | tap(13) | tap(4);
      17: m = tap(17) | tap(14);
      18: m = tap(18) | tap(11);
      19: m = tap(19) | tap(6)  | tap(2) | tap(1);
      20: m = tap(20) | tap(17);
      21: m = tap(21) | tap(19);
      22: m = tap(22) | tap(21);
      23: m = tap(23) | tap(18);
      24: m = tap(24) | tap(23) | tap(22) | tap(17);
      25: m = tap(25) | tap(22);
      26: m = tap(26) | tap(6)  | tap(2) | tap(1);
      27: m = tap(27) | tap(5)  | tap(2) | tap(1);
      28: m = tap(28) | tap(25);
      29: m = tap(29) | tap(27);
      30: m = tap(30) | tap(6)  | tap(4) | tap(1);
      31: m = tap(31) | tap(28);
      32: m = tap(32) | tap(22) | tap(2) | tap(1);
      default: m = '0;
    endcase
    return m;
  endfunction

  localparam logic [NUM_BITS-1:0] TAPS = NUM_BITS'(tap_mask(NUM_BITS));

  logic [NUM_BITS-1:0] r_q;
  logic                fb;

  // XNOR feedback: all-zeros is a valid state, all-ones is the lockup state.
  assign fb = ~(^(r_q & TAPS));

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_q <= '0;
    end else if (i_Enable) begin
      if (i_Seed_DV) begin
        r_q <= i_Seed_Data;
      end else begin
        r_q <= {r_q[NUM_BITS-2:0], fb};
      end
    end
  end

  assign o_LFSR_Data = r_q;
  assign o_LFSR_Done = (r_q == i_Seed_Data);

endmodule

// File: tb/tb_lfsr.sv
// Self-checking bench for lfsr at widths 3, 8 and 32 sharing one clock,
// reset and control; expected states are queued as stimulus is driven.
module tb_lfsr;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        seed_dv;
  logic [2:0]  seed3;
  logic [7:0]  seed8;
  logic [31:0] seed32;
  logic [2:0]  data3;
  logic [7:0]  data8;
  logic [31:0] data32;
  logic        done3, done8, done32;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  exp_q8[$];
  logic [2:0]  exp_q3[$];

  lfsr #(.NUM_BITS(3)) dut3 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(enable), .i_Seed_DV(seed_dv),
    .i_Seed_Data(seed3), .o_LFSR_Data(data3), .o_LFSR_Done(done3));

  lfsr #(.NUM_BITS(8)) dut8 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(enable), .i_Seed_DV(seed_dv),
    .i_Seed_Data(seed8), .o_LFSR_Data(data8), .o_LFSR_Done(done8));

  lfsr #(.NUM_BITS(32)) dut32 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(enable), .i_Seed_DV(seed_dv),
    .i_Seed_Data(seed32), .o_LFSR_Data(data32), .o_LFSR_Done(done32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  // Reference next-state for the 8-bit XNOR LFSR with taps 8,6,5,4.
  function automatic logic [7:0] model8(input logic [7:0] r);
    logic x;
    x = r[7] ^ r[5] ^ r[4] ^ r[3];
    return {r[6:0], ~x};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    enable  = 1'b0;
    seed_dv = 1'b0;
    #7;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; enable = 1'b0; seed_dv = 1'b0;
    seed3 = 3'd0; seed8 = 8'h00; seed32 = 32'h0;
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (data8 !== 8'h00) begin
      n_fail++; $display("FAIL reset_data8: got %h, expected 00", data8);
    end
    n_checks++;
    if (data32 !== 32'h0) begin
      n_fail++; $display("FAIL reset_data32: got %h, expected 00000000", data32);
    end
    n_checks++;
    if (done8 !== 1'b1) begin
      n_fail++; $display("FAIL reset_done_seed0: got %b, expected 1", done8);
    end
    seed8 = 8'h5A;
    #1;
    n_checks++;
    if (done8 !== 1'b0) begin
      n_fail++; $display("FAIL reset_done_seed5a: got %b, expected 0", done8);
    end
    // Clock edges with enable and seed strobe must not disturb reset.
    enable = 1'b1; seed_dv = 1'b1;
    tick();
    n_checks++;
    if (data8 !== 8'h00) begin
      n_fail++; $display("FAIL reset_priority: got %h, expected 00", data8);
    end
    enable = 1'b0; seed_dv = 1'b0; seed8 = 8'h00;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_seq3();
    logic [2:0] tbl [0:7];
    logic [2:0] e;
    tbl = '{3'b000, 3'b001, 3'b011, 3'b110, 3'b101, 3'b010, 3'b100, 3'b000};
    do_reset();
    seed3 = 3'b000;
    n_checks++;
    if (data3 !== tbl[0]) begin
      n_fail++; $display("FAIL seq3_start: got %b, expected %b", data3, tbl[0]);
    end
    enable = 1'b1;
    for (int i = 1; i < 8; i++) begin
      exp_q3.push_back(tbl[i]);
      tick();
      e = exp_q3.pop_front();
      n_checks++;
      if (data3 !== e) begin
        n_fail++; $display("FAIL seq3_step%0d: got %b, expected %b", i, data3, e);
      end
      n_checks++;
      if (done3 !== (i == 7)) begin
        n_fail++; $display("FAIL seq3_done%0d: got %b, expected %b", i, done3, (i == 7));
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_seed32();
    do_reset();
    seed32 = 32'h0000_70EC;
    enable = 1'b1; seed_dv = 1'b1;
    tick();
    seed_dv = 1'b0;
    n_checks++;
    if (data32 !== 32'h0000_70EC) begin
      n_fail++; $display("FAIL seed32_load: got %h, expected 000070ec", data32);
    end
    n_checks++;
    if (done32 !== 1'b1) begin
      n_fail++; $display("FAIL seed32_done: got %b, expected 1", done32);
    end
    tick();
    enable = 1'b0;
    n_checks++;
    if (data32 !== 32'h0000_E1D9) begin
      n_fail++; $display("FAIL seed32_shift: got %h, expected 0000e1d9", data32);
    end
    n_checks++;
    if (done32 !== 1'b0) begin
      n_fail++; $display("FAIL seed32_done_after: got %b, expected 0", done32);
    end
  endtask

  task automatic test_period8();
    logic [7:0] model;
    logic [7:0] e;
    bit         seen [256];
    int         done_cnt;
    int         done_at;
    int         seen_cnt;
    do_reset();
    seed8 = 8'h00;
    model = 8'h00;
    done_cnt = 0; done_at = -1;
    foreach (seen[i]) seen[i] = 1'b0;
    enable = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      model = model8(model);
      exp_q8.push_back(model);
      tick();
      e = exp_q8.pop_front();
      n_checks++;
      if (data8 !== e) begin
        n_fail++; $display("FAIL period8_step%0d: got %h, expected %h", i, data8, e);
      end
      if (!seen[data8]) seen_cnt++;
      seen[data8] = 1'b1;
      if (done8 === 1'b1) begin
        done_cnt++; done_at = i;
      end
    end
    enable = 1'b0;
    n_checks++;
    if (done_cnt !== 1 || done_at !== 255) begin
      n_fail++; $display("FAIL period8_done: got %0d assertions last at edge %0d, expected 1 at 255",
                         done_cnt, done_at);
    end
    seen_cnt = 0;
    for (int v = 0; v < 255; v++) if (seen[v]) seen_cnt++;
    n_checks++;
    if (seen_cnt !== 255 || seen[255]) begin
      n_fail++; $display("FAIL period8_coverage: got %0d distinct non-FF (FF seen=%0d), expected 255 (FF seen=0)",
                         seen_cnt, seen[255]);
    end
  endtask

  task automatic test_hold();
    logic [7:0] held;
    do_reset();
    enable = 1'b1;
    repeat (3) tick();
    enable = 1'b0;
    held = data8;
    for (int i = 0; i < 5; i++) begin
      seed_dv = ~seed_dv;
      seed8   = 8'h3C ^ 8'(i);
      tick();
      n_checks++;
      if (data8 !== held) begin
        n_fail++; $display("FAIL hold_edge%0d: got %h, expected %h", i, data8, held);
      end
    end
    seed_dv = 1'b0;
  endtask

  task automatic test_lockup();
    do_reset();
    seed8 = 8'hFF;
    enable = 1'b1; seed_dv = 1'b1;
    tick();
    seed_dv = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (data8 !== 8'hFF) begin
        n_fail++; $display("FAIL lockup_shift%0d: got %h, expected ff", i, data8);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    enable = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (data8 === 8'h00) begin
      n_fail++; $display("FAIL async_pre: got %h, expected nonzero", data8);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (data8 !== 8'h00 || data32 !== 32'h0) begin
      n_fail++; $display("FAIL async_reset: got %h/%h, expected 00/00000000", data8, data32);
    end
    #2;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (data8 !== 8'h01) begin
      n_fail++; $display("FAIL async_resume: got %h, expected 01", data8);
    end
    enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] model;
    logic [7:0] e;
    logic [7:0] seeds [0:2];
    seeds = '{8'hA5, 8'h13, 8'h7E};
    do_reset();
    enable = 1'b1; seed_dv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      seed8 = seeds[i];
      model = seeds[i];
      exp_q8.push_back(model);
      tick();
      e = exp_q8.pop_front();
      n_checks++;
      if (data8 !== e || done8 !== 1'b1) begin
        n_fail++; $display("FAIL b2b_load%0d: got %h done=%b, expected %h done=1", i, data8, done8, e);
      end
    end
    seed_dv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      model = model8(model);
      exp_q8.push_back(model);
      tick();
      e = exp_q8.pop_front();
      n_checks++;
      if (data8 !== e) begin
        n_fail++; $display("FAIL b2b_shift%0d: got %h, expected %h", i, data8, e);
      end
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_seq3();
    test_seed32();
    test_period8();
    test_hold();
    test_lockup();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
